// File: rtl/share_gen.sv
// share_gen: splits each secret word into two Boolean shares (X = secret ^ mask, Y = mask)
// and drives them, with a start pulse, to the first-order share reader.
// Revision 1.0
`default_nettype none

module share_gen #(
  parameter int                     BUSWIDTH     = 32,
  parameter int                     HOLD_CYCLES  = 2,
  parameter int                     DRAIN_CYCLES = 6,
  parameter logic [BUSWIDTH-1:0]    POLY         = 32'h80200003,
  parameter logic [BUSWIDTH-1:0]    RESET_SEED   = 32'h00000001
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [BUSWIDTH-1:0] data_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [BUSWIDTH-1:0] seed_i,
  input  logic                seed_we_i,
  output logic [BUSWIDTH-1:0] X_o,
  output logic [BUSWIDTH-1:0] Y_o,
  output logic                start_o,
  output logic                busy_o
);

  localparam logic [3:0] c_HOLD_M1  = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] c_DRAIN_M1 = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [BUSWIDTH-1:0] r_lfsr;
  logic [BUSWIDTH-1:0] r_x;
  logic [BUSWIDTH-1:0] r_y;
  logic                r_start;
  logic                r_busy;
  logic                r_ready;

  logic [BUSWIDTH-1:0] w_seed_val;
  logic [BUSWIDTH-1:0] w_lfsr_base;
  logic [BUSWIDTH-1:0] w_mask;

  function automatic logic [BUSWIDTH-1:0] f_step(input logic [BUSWIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  // A zero seed would lock the LFSR, so it falls back to RESET_SEED.
  assign w_seed_val  = (seed_i == '0) ? RESET_SEED : seed_i;
  assign w_lfsr_base = seed_we_i ? w_seed_val : r_lfsr;
  assign w_mask      = f_step(w_lfsr_base);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_lfsr  <= RESET_SEED;
      r_x     <= '0;
      r_y     <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_lfsr  <= w_mask;
            r_x     <= data_i ^ w_mask;
            r_y     <= w_mask;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_cnt   <= c_HOLD_M1;
            r_state <= S_DRIVE;
          end else if (seed_we_i) begin
            r_lfsr <= w_seed_val;
          end
        end
        S_DRIVE: begin
          if (r_cnt == 4'd0) begin
            r_start <= 1'b0;
            r_cnt   <= c_DRAIN_M1;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DRAIN: begin
          // Shares stay held here: the reader latches once more as start falls.
          if (r_cnt == 4'd0) begin
            r_x     <= '0;
            r_y     <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_x     <= '0;
          r_y     <= '0;
        end
      endcase
    end
  end

  assign X_o     = r_x;
  assign Y_o     = r_y;
  assign start_o = r_start;
  assign busy_o  = r_busy;
  assign ready_o = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_share_gen.sv
// Testbench for share_gen: directed and random words checked against a word-level model.
// Revision 1.0
`default_nettype none

module tb_share_gen;

  localparam int          HOLD  = 2;
  localparam int          DRAIN = 6;
  localparam logic [31:0] POLY  = 32'h80200003;
  localparam logic [31:0] SEED0 = 32'h00000001;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] seed_i = '0;
  logic        seed_we_i = 1'b0;
  logic [31:0] X_o;
  logic [31:0] Y_o;
  logic        start_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_lfsr;

  share_gen dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .seed_i   (seed_i),
    .seed_we_i(seed_we_i),
    .X_o      (X_o),
    .Y_o      (Y_o),
    .start_o  (start_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
    chk({tag, "_busy"},  {31'd0, busy_o},  32'd0);
    chk({tag, "_start"}, {31'd0, start_o}, 32'd0);
    chk({tag, "_x"}, X_o, 32'd0);
    chk({tag, "_y"}, Y_o, 32'd0);
  endtask

  // One complete word: accept, then the whole hold/drain window, optionally with
  // junk on valid/seed while busy, then back to idle.
  task automatic send(input logic [31:0] data, input logic we, input logic [31:0] seed,
                      input bit noise, input bit use_dir, input logic [31:0] dir_y,
                      input logic [31:0] dir_x);
    logic [31:0] mask;
    chk("pre_ready", {31'd0, ready_o}, 32'd1);
    data_i    = data;
    valid_i   = 1'b1;
    seed_we_i = we;
    seed_i    = seed;
    if (we) m_lfsr = (seed == 32'd0) ? SEED0 : seed;
    mask   = step(m_lfsr);
    m_lfsr = mask;
    tick();
    valid_i   = 1'b0;
    seed_we_i = 1'b0;
    if (use_dir) begin
      chk("dir_y", Y_o, dir_y);
      chk("dir_x", X_o, dir_x);
    end
    chk("unmask", X_o ^ Y_o, data);
    for (int j = 0; j < HOLD + DRAIN; j++) begin
      chk("y_hold", Y_o, mask);
      chk("x_hold", X_o, data ^ mask);
      chk("start", {31'd0, start_o}, {31'd0, (j < HOLD)});
      chk("busy",  {31'd0, busy_o},  32'd1);
      chk("ready", {31'd0, ready_o}, 32'd0);
      if (noise) begin
        valid_i   = 1'($urandom);
        seed_we_i = 1'($urandom);
        seed_i    = $urandom;
        data_i    = $urandom;
      end
      tick();
    end
    valid_i   = 1'b0;
    seed_we_i = 1'b0;
    chk_idle("post");
  endtask

  initial begin
    m_lfsr = SEED0;
    #12;
    chk_idle("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    chk_idle("released");

    // Case 1 and 2: first masks from the reset seed.
    send(32'hDEADBEEF, 1'b0, 32'd0, 1'b0, 1'b1, 32'h80200003, 32'h5E8DBEEC);
    send(32'h00000000, 1'b0, 32'd0, 1'b0, 1'b1, 32'hC0300002, 32'hC0300002);

    // Case 3: zero seed with simultaneous valid.
    send(32'hFFFFFFFF, 1'b1, 32'd0, 1'b0, 1'b1, 32'h80200003, 32'h7FDFFFFC);

    // Case 4: junk on seed/valid while busy must not disturb the sequence.
    send(32'hA5A5A5A5, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    send(32'h3C3C3C3C, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Idle reseed without valid, then a word.
    seed_i = 32'h13579BDF;
    seed_we_i = 1'b1;
    m_lfsr = 32'h13579BDF;
    tick();
    seed_we_i = 1'b0;
    chk_idle("reseed");
    send(32'h12345678, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Case 5: asynchronous reset in the second DRIVE cycle.
    data_i  = 32'h0F0F0F0F;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    chk("abort_pre_start", {31'd0, start_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk_idle("abort");
    @(negedge clk_i);
    rst_ni = 1'b1;
    m_lfsr = SEED0;
    tick();
    send(32'h0BADF00D, 1'b0, 32'd0, 1'b0, 1'b1, 32'h80200003, 32'h0BADF00D ^ 32'h80200003);

    // Case 6 essence plus random traffic.
    send(32'h12345678, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < 20; k++) begin
      logic        we;
      logic [31:0] sd;
      we = ($urandom_range(0, 3) == 0);
      sd = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      send($urandom, we, sd, 1'($urandom), 1'b0, 32'd0, 32'd0);
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk_idle("gap");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
